// File: rtl/multi_channel_scoreboard.sv
// Scoreboard monitor that follows one magic packet through an N-channel tagged datapath.
// Optional watchdog enabled by defining SB_TIMEOUT_EN (adds the sticky timeout output).
module multi_channel_scoreboard #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TAGW    = $clog2(NUM_CH),
    parameter int unsigned CNTWID  = $clog2(DEPTH) + 1,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       push,
    input  logic [NUM_CH*WIDTH-1:0] flat_data_in,
    input  logic                    start,
    input  logic [TAGW-1:0]         sel_ch,
    input  logic                    out_vld,
    input  logic [WIDTH-1:0]        out_data,
    output logic                    captured,
    output logic                    data_out_vld,
    output logic                    prop_signal,
    output logic                    fail,
    output logic                    err_ovf,
    output logic                    err_udf
`ifdef SB_TIMEOUT_EN
    ,
    output logic                    timeout
`endif
);

    typedef enum logic [1:0] {ARM, TRACK, DONE} state_e;

    if (NUM_CH < 2 || TIMEOUT == 0) begin : g_bad_cfg
        $error("multi_channel_scoreboard: NUM_CH must be >= 2 and TIMEOUT > 0");
    end

    state_e              state_q, state_d;
    logic [CNTWID-1:0]   occ_q [NUM_CH];
    logic [CNTWID-1:0]   occ_d [NUM_CH];
    logic [CNTWID-1:0]   cnt_q, cnt_d;
    logic [TAGW-1:0]     trk_ch_q, trk_ch_d;
    logic [WIDTH-1:0]    magic_q, magic_d;
    logic                captured_q, captured_d;
    logic                fail_q, fail_d;
    logic                ovf_q, ovf_d;
    logic                udf_q, udf_d;

`ifdef SB_TIMEOUT_EN
    localparam int unsigned TMOW = $clog2(TIMEOUT + 1);
    logic [TMOW-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic                tmo_q, tmo_d;
`endif

    logic [TAGW-1:0]     out_tag;
    logic [NUM_CH-1:0]   pop_vec;
    logic                tag_ok;
    logic                sel_push, sel_pop, trk_pop, match;
    logic [CNTWID-1:0]   sel_occ;
    logic [WIDTH-1:0]    sel_data;

    assign out_tag = out_data[WIDTH-1 -: TAGW];
    assign match   = (out_data == magic_q);

    // Tag decode: which channel (if any) the emitted packet is departing from
    always_comb begin
        pop_vec  = '0;
        tag_ok   = 1'b0;
        sel_push = 1'b0;
        sel_pop  = 1'b0;
        sel_occ  = '0;
        sel_data = '0;
        trk_pop  = 1'b0;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            if (out_tag == TAGW'(c)) begin
                tag_ok     = 1'b1;
                pop_vec[c] = out_vld;
            end
        end
        for (int c = 0; c < int'(NUM_CH); c++) begin
            if (sel_ch == TAGW'(c)) begin
                sel_push = push[c];
                sel_pop  = pop_vec[c];
                sel_occ  = occ_q[c];
                sel_data = flat_data_in[c*WIDTH +: WIDTH];
            end
            if (trk_ch_q == TAGW'(c)) begin
                trk_pop = pop_vec[c];
            end
        end
    end

    // Shadow occupancy with saturation; out-of-range tags count as underflow
    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q | (out_vld & ~tag_ok);
        for (int c = 0; c < int'(NUM_CH); c++) begin
            occ_d[c] = occ_q[c];
            case ({push[c], pop_vec[c]})
                2'b10: begin
                    if (occ_q[c] == CNTWID'(DEPTH)) ovf_d = 1'b1;
                    else                            occ_d[c] = occ_q[c] + CNTWID'(1);
                end
                2'b01: begin
                    if (occ_q[c] == '0) udf_d = 1'b1;
                    else                occ_d[c] = occ_q[c] - CNTWID'(1);
                end
                default: ;
            endcase
        end
    end

    // Capture / track / check state machine
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        trk_ch_d     = trk_ch_q;
        magic_d      = magic_q;
        fail_d       = fail_q;
        data_out_vld = 1'b0;
`ifdef SB_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
        tmo_d        = tmo_q;
`endif
        case (state_q)
            ARM: begin
                if (start && sel_push && (sel_occ < CNTWID'(DEPTH))) begin
                    state_d  = TRACK;
                    trk_ch_d = sel_ch;
                    magic_d  = sel_data;
                    cnt_d    = sel_occ + CNTWID'(1) - CNTWID'(sel_pop);
`ifdef SB_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
            end
            TRACK: begin
                if (trk_pop && (cnt_q != '0)) begin
                    cnt_d = cnt_q - CNTWID'(1);
                end
                if (trk_pop && (cnt_q == CNTWID'(1))) begin
                    data_out_vld = 1'b1;
                    fail_d       = fail_q | ~match;
                    state_d      = DONE;
                end
`ifdef SB_TIMEOUT_EN
                else if (tmo_cnt_q == TMOW'(TIMEOUT - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMOW'(1);
                end
`endif
            end
            DONE: begin
                if (!start) state_d = ARM;
            end
            default: state_d = ARM;
        endcase
        captured_d = (state_d == TRACK);
    end

    assign prop_signal = ~data_out_vld | match;
    assign captured    = captured_q;
    assign fail        = fail_q;
    assign err_ovf     = ovf_q;
    assign err_udf     = udf_q;
`ifdef SB_TIMEOUT_EN
    assign timeout     = tmo_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ARM;
            cnt_q      <= '0;
            trk_ch_q   <= '0;
            magic_q    <= '0;
            captured_q <= 1'b0;
            fail_q     <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            for (int c = 0; c < int'(NUM_CH); c++) occ_q[c] <= '0;
`ifdef SB_TIMEOUT_EN
            tmo_cnt_q  <= '0;
            tmo_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            trk_ch_q   <= trk_ch_d;
            magic_q    <= magic_d;
            captured_q <= captured_d;
            fail_q     <= fail_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            for (int c = 0; c < int'(NUM_CH); c++) occ_q[c] <= occ_d[c];
`ifdef SB_TIMEOUT_EN
            tmo_cnt_q  <= tmo_cnt_d;
            tmo_q      <= tmo_d;
`endif
        end
    end

endmodule

// File: tb/tb_multi_channel_scoreboard.sv
// Bench for multi_channel_scoreboard: directed steps then random traffic against a
// packet-queue reference model (each channel is a queue of packet ids).
module tb_multi_channel_scoreboard;

    localparam int NUM_CH = 4;
    localparam int WIDTH  = 8;
    localparam int DEPTH  = 8;
    localparam int TAGW   = 2;
    localparam int TMO    = 10;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic [NUM_CH-1:0]       push = '0;
    logic [NUM_CH*WIDTH-1:0] flat_data_in = '0;
    logic                    start = 1'b0;
    logic [TAGW-1:0]         sel_ch = '0;
    logic                    out_vld = 1'b0;
    logic [WIDTH-1:0]        out_data = '0;
    logic                    captured, data_out_vld, prop_signal, fail, err_ovf, err_udf;
`ifdef SB_TIMEOUT_EN
    logic                    timeout;
`endif

    multi_channel_scoreboard #(
        .NUM_CH(NUM_CH), .WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .push(push), .flat_data_in(flat_data_in),
        .start(start), .sel_ch(sel_ch), .out_vld(out_vld), .out_data(out_data),
        .captured(captured), .data_out_vld(data_out_vld), .prop_signal(prop_signal),
        .fail(fail), .err_ovf(err_ovf), .err_udf(err_udf)
`ifdef SB_TIMEOUT_EN
        , .timeout(timeout)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: 0 = waiting for capture, 1 = magic in flight, 2 = checked
    int         mq [NUM_CH][$];
    int         m_state, m_trk, m_magic_id, m_tcyc, next_id;
    logic [7:0] m_magic;
    bit         m_fail, m_ovf, m_udf, m_tmo;
    bit         exp_dov, exp_prop;
    logic       obs_dov, obs_prop;
    logic [7:0] ch_data [NUM_CH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) mq[c].delete();
        m_state = 0; m_trk = 0; m_magic_id = -1; m_tcyc = 0; m_magic = '0;
        m_fail = 0; m_ovf = 0; m_udf = 0; m_tmo = 0;
    endtask

    task automatic model_comb();
        int t;
        t = int'(out_data[WIDTH-1 -: TAGW]);
        exp_dov = 0;
        if (m_state == 1 && out_vld && t == m_trk && mq[m_trk].size() > 0)
            exp_dov = (mq[m_trk][0] == m_magic_id);
        exp_prop = !exp_dov || (out_data == m_magic);
    endtask

    task automatic model_clock();
        int popc;
        int s;
        int pre_n [NUM_CH];
        int new_id [NUM_CH];
        popc = out_vld ? int'(out_data[WIDTH-1 -: TAGW]) : -1;
        s = int'(sel_ch);
        for (int c = 0; c < NUM_CH; c++) begin
            pre_n[c]  = mq[c].size();
            new_id[c] = next_id++;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (push[c] && popc == c) begin
                if (pre_n[c] > 0) begin
                    void'(mq[c].pop_front());
                    mq[c].push_back(new_id[c]);
                end
            end else if (push[c]) begin
                if (pre_n[c] == DEPTH) m_ovf = 1;
                else mq[c].push_back(new_id[c]);
            end else if (popc == c) begin
                if (pre_n[c] == 0) m_udf = 1;
                else void'(mq[c].pop_front());
            end
        end
        case (m_state)
            0: if (start && push[s] && pre_n[s] < DEPTH) begin
                m_state = 1; m_trk = s; m_magic_id = new_id[s]; m_magic = ch_data[s]; m_tcyc = 0;
            end
            1: begin
                if (exp_dov) begin
                    if (out_data != m_magic) m_fail = 1;
                    m_state = 2;
                end
`ifdef SB_TIMEOUT_EN
                else if (m_tcyc == TMO - 1) begin
                    m_tmo = 1; m_state = 2;
                end else m_tcyc++;
`endif
            end
            default: if (!start) m_state = 0;
        endcase
    endtask

    task automatic check_regs();
        chk("captured", captured, (m_state == 1));
        chk("fail", fail, m_fail);
        chk("err_ovf", err_ovf, m_ovf);
        chk("err_udf", err_udf, m_udf);
`ifdef SB_TIMEOUT_EN
        chk("timeout", timeout, m_tmo);
`endif
    endtask

    // One clock: combinational outputs checked at negedge, registered ones after the edge
    task automatic cycle();
        @(negedge clk);
        model_comb();
        obs_dov  = data_out_vld;
        obs_prop = prop_signal;
        chk("data_out_vld", obs_dov, exp_dov);
        chk("prop_signal", obs_prop, exp_prop);
        model_clock();
        @(posedge clk);
        #1;
        check_regs();
    endtask

    task automatic apply(input logic [3:0] p, input logic st, input logic [1:0] sel,
                         input logic ov, input logic [7:0] od);
        push = p; start = st; sel_ch = sel; out_vld = ov; out_data = od;
        for (int c = 0; c < NUM_CH; c++) flat_data_in[c*WIDTH +: WIDTH] = ch_data[c];
        cycle();
    endtask

    initial begin
        logic [1:0] xtags [5];
        logic [3:0] rp;
        logic       rst_st, rov;
        logic [1:0] rsel, rtag;
        logic [7:0] rod;

        xtags[0] = 2'd0; xtags[1] = 2'd1; xtags[2] = 2'd2; xtags[3] = 2'd0; xtags[4] = 2'd1;
        next_id = 0;
        for (int c = 0; c < NUM_CH; c++) ch_data[c] = '0;
        model_reset();

        // Reset values
        #12;
        chk("rst_captured", captured, 1'b0);
        chk("rst_dov", data_out_vld, 1'b0);
        chk("rst_prop", prop_signal, 1'b1);
        chk("rst_fail", fail, 1'b0);
        chk("rst_ovf", err_ovf, 1'b0);
        chk("rst_udf", err_udf, 1'b0);
        @(posedge clk); #1; rst = 1'b1;

        // Empty queue, fast exit
        ch_data[1] = 8'h4A;
        apply(4'b0010, 1'b1, 2'd1, 1'b0, 8'h00);
        chk("t1_captured", captured, 1'b1);
        apply(4'b0000, 1'b1, 2'd1, 1'b1, 8'h4A);
        chk("t1_exit_dov", obs_dov, 1'b1);
        chk("t1_exit_prop", obs_prop, 1'b1);
        chk("t1_fail", fail, 1'b0);
        apply(4'b0000, 1'b0, 2'd0, 1'b0, 8'h00);

        // Three packets queued ahead on ch2
        ch_data[2] = 8'h81; apply(4'b0100, 1'b0, 2'd0, 1'b0, 8'h00);
        ch_data[2] = 8'h82; apply(4'b0100, 1'b0, 2'd0, 1'b0, 8'h00);
        ch_data[2] = 8'h83; apply(4'b0100, 1'b0, 2'd0, 1'b0, 8'h00);
        ch_data[2] = 8'h8C; apply(4'b0100, 1'b1, 2'd2, 1'b0, 8'h00);
        chk("t2_captured", captured, 1'b1);
        apply(4'b0000, 1'b0, 2'd0, 1'b1, 8'h81); chk("t2_pop1", obs_dov, 1'b0);
        apply(4'b0000, 1'b0, 2'd0, 1'b1, 8'h82); chk("t2_pop2", obs_dov, 1'b0);
        apply(4'b0000, 1'b0, 2'd0, 1'b1, 8'h83); chk("t2_pop3", obs_dov, 1'b0);
        apply(4'b0000, 1'b0, 2'd0, 1'b1, 8'h8C); chk("t2_pop4", obs_dov, 1'b1);
        apply(4'b0000, 1'b0, 2'd0, 1'b0, 8'h00);

        // Corrupted exit on ch0 (0x15 captured, 0x14 emitted, both tag 0)
        ch_data[0] = 8'h15;
        apply(4'b0001, 1'b1, 2'd0, 1'b0, 8'h00);
        apply(4'b0000, 1'b0, 2'd0, 1'b1, 8'h14);
        chk("t3_dov", obs_dov, 1'b1);
        chk("t3_prop", obs_prop, 1'b0);
        chk("t3_fail", fail, 1'b1);
        apply(4'b0000, 1'b0, 2'd0, 1'b0, 8'h00);

        // Cross-channel traffic while tracking ch3
        ch_data[0] = 8'h01; ch_data[1] = 8'h41; ch_data[2] = 8'h81;
        apply(4'b0111, 1'b0, 2'd0, 1'b0, 8'h00);
        apply(4'b0111, 1'b0, 2'd0, 1'b0, 8'h00);
        ch_data[3] = 8'hC3;
        apply(4'b1000, 1'b1, 2'd3, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            apply(4'b0000, 1'b0, 2'd0, 1'b1, {xtags[i], 6'h0C});
            chk("t4_cross", obs_dov, 1'b0);
        end
        apply(4'b0000, 1'b0, 2'd0, 1'b1, 8'hC3);
        chk("t4_exit", obs_dov, 1'b1);

        // Overflow: DEPTH pushes fill ch0, one more flags it
        ch_data[0] = 8'h07;
        for (int i = 0; i < DEPTH; i++) apply(4'b0001, 1'b0, 2'd0, 1'b0, 8'h00);
        chk("ovf_at_full", err_ovf, 1'b0);
        apply(4'b0001, 1'b0, 2'd0, 1'b0, 8'h00);
        chk("ovf_set", err_ovf, 1'b1);
        apply(4'b0001, 1'b1, 2'd0, 1'b0, 8'h00);
        chk("no_capture_full", captured, 1'b0);
        apply(4'b0000, 1'b0, 2'd0, 1'b0, 8'h00);

        // Push+pop on ch1 at occ=2 keeps occ at 2; third pop underflows
        ch_data[1] = 8'h41;
        apply(4'b0010, 1'b0, 2'd0, 1'b0, 8'h00);
        apply(4'b0010, 1'b0, 2'd0, 1'b0, 8'h00);
        apply(4'b0010, 1'b0, 2'd0, 1'b1, 8'h41);
        apply(4'b0000, 1'b0, 2'd0, 1'b1, 8'h41);
        apply(4'b0000, 1'b0, 2'd0, 1'b1, 8'h41);
        chk("udf_clear", err_udf, 1'b0);
        apply(4'b0000, 1'b0, 2'd0, 1'b1, 8'h41);
        chk("udf_set", err_udf, 1'b1);

        // Reset mid-track abandons everything
        ch_data[1] = 8'h4B;
        apply(4'b0010, 1'b1, 2'd1, 1'b0, 8'h00);
        chk("mid_captured", captured, 1'b1);
        push = '0; start = 1'b0; out_vld = 1'b0;
        #2; rst = 1'b0; #1;
        model_reset();
        chk("mid_rst_captured", captured, 1'b0);
        chk("mid_rst_fail", fail, 1'b0);
        chk("mid_rst_ovf", err_ovf, 1'b0);
        chk("mid_rst_udf", err_udf, 1'b0);
        chk("mid_rst_prop", prop_signal, 1'b1);
        @(posedge clk); #1; rst = 1'b1;

`ifdef SB_TIMEOUT_EN
        // Watchdog: no pops for TIMEOUT cycles
        ch_data[2] = 8'h9A;
        apply(4'b0100, 1'b1, 2'd2, 1'b0, 8'h00);
        for (int i = 0; i < TMO - 1; i++) apply(4'b0000, 1'b1, 2'd2, 1'b0, 8'h00);
        chk("tmo_before", timeout, 1'b0);
        apply(4'b0000, 1'b1, 2'd2, 1'b0, 8'h00);
        chk("tmo_set", timeout, 1'b1);
        chk("tmo_captured", captured, 1'b0);
        chk("tmo_fail", fail, 1'b0);
        apply(4'b0000, 1'b0, 2'd0, 1'b0, 8'h00);
        apply(4'b0100, 1'b1, 2'd2, 1'b0, 8'h00);
        chk("tmo_rearm", captured, 1'b1);
`endif

        // Random traffic
        rst_st = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                rp[c] = ($urandom_range(0, 7) == 0);
                ch_data[c] = {2'(c), 6'($urandom_range(0, 63))};
            end
            if ($urandom_range(0, 3) == 0) rst_st = ~rst_st;
            rsel = 2'($urandom_range(0, 3));
            rov  = ($urandom_range(0, 1) == 1);
            rtag = 2'($urandom_range(0, 3));
            rod  = {rtag, 6'($urandom_range(0, 63))};
            if (m_state == 1 && int'(rtag) == m_trk && mq[m_trk].size() > 0 &&
                mq[m_trk][0] == m_magic_id && $urandom_range(0, 15) != 0)
                rod = m_magic;
            if (m_state == 0 && rst_st && rtag == rsel && mq[int'(rsel)].size() == 0)
                rov = 1'b0;
            apply(rp, rst_st, rsel, rov, rod);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
